// File: rtl/ula_pkg.sv
// ula_pkg: funct codes, ULA control codes and muldiv FSM encoding for ula_ctrl_muldiv.
package ula_pkg;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [3:0] ULA_AND  = 4'b0000;
  localparam logic [3:0] ULA_OR   = 4'b0001;
  localparam logic [3:0] ULA_ADD  = 4'b0010;
  localparam logic [3:0] ULA_SUB  = 4'b0110;
  localparam logic [3:0] ULA_SLT  = 4'b0111;
  localparam logic [3:0] ULA_SLTU = 4'b1000;
  localparam logic [3:0] ULA_NOR  = 4'b1100;
  localparam logic [3:0] ULA_BAD  = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} md_state_e;
  function automatic logic is_md(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction
  function automatic logic is_hilo(input logic [5:0] f);
    return f[5:2] == 4'b0100;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: WIDTH-step shift-add multiply / restoring divide on magnitudes, sign fix in FIX.
module muldiv_iter
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             wr,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, ma, mb;
  logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, done_q, rem_ge;
  logic [WIDTH:0] sum, rem_t;
  logic [2*WIDTH-1:0] prod;
  assign ma = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign mb = (op_sgn && b[WIDTH-1]) ? -b : b;
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= st_q == S_FIX;
    end
  end
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    hi_q  <= hi_d;
    lo_q  <= lo_d;
    b_q   <= b_d;
    div_q <= div_d;
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    bz_q  <= bz_d;
  end
  always_comb begin
    st_d = st_q;
    if (st_q == S_IDLE && start) st_d = S_RUN;
    else if (st_q == S_RUN && cnt_q == '0) st_d = S_FIX;
    else if (st_q == S_FIX) st_d = S_IDLE;
  end
  // lo holds the multiplier (mul) or dividend (div); both shift out one bit per step
  always_comb begin
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_t  = {hi_q, lo_q[WIDTH-1]};
    rem_ge = rem_t >= {1'b0, b_q};
    cnt_d  = st_q == S_IDLE ? CW'(WIDTH-1) : cnt_q - CW'(1);
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    div_d  = div_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    bz_d   = bz_q;
    if (st_q == S_IDLE && start) begin
      hi_d  = '0;
      lo_d  = ma;
      b_d   = mb;
      div_d = op_div;
      sa_d  = op_sgn & a[WIDTH-1];
      sb_d  = op_sgn & b[WIDTH-1];
      bz_d  = b == '0;
    end else if (st_q == S_RUN && div_q) begin
      hi_d = rem_ge ? WIDTH'(rem_t - {1'b0, b_q}) : rem_t[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], rem_ge};
    end else if (st_q == S_RUN) begin
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end
  end
  always_comb begin
    busy = st_q != S_IDLE;
    wr   = st_q == S_FIX;
    done = done_q;
    prod = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
    res_hi = div_q ? (sa_q ? -hi_q : hi_q) : prod[2*WIDTH-1:WIDTH];
    res_lo = !div_q ? prod[WIDTH-1:0] : bz_q ? {WIDTH{1'b1}} : (sa_q ^ sb_q) ? -lo_q : lo_q;
  end
endmodule

// File: rtl/ula_ctrl_muldiv.sv
// ula_ctrl_muldiv: MIPS ALU control decode plus HI/LO and iterative mul/div with stall.
// Define MULDIV_DIVZERO_EXC_EN to trap divide-by-zero instead of running it.
module ula_ctrl_muldiv
  import ula_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ULAOp,
  input  logic [5:0]        funct,
  input  logic              op_valid,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  output logic [CTRL_W-1:0] ULActrl,
  output logic              illegal,
  output logic [WIDTH-1:0]  mf_data,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  output logic              div_zero_exc
);
  logic [3:0] ctrl;
  logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
  logic r_type, start_req, start, md_busy, wr;
  always_comb begin
    ctrl    = ULA_ADD;
    illegal = 1'b0;
    if (ULAOp[0]) ctrl = ULA_SUB;
    else if (ULAOp == 2'b10) begin
      case (funct)
        F_ADD, F_ADDU, F_MULT, F_MULTU, F_DIV, F_DIVU,
        F_MFHI, F_MTHI, F_MFLO, F_MTLO: ctrl = ULA_ADD;
        F_SUB, F_SUBU: ctrl = ULA_SUB;
        F_AND:  ctrl = ULA_AND;
        F_OR:   ctrl = ULA_OR;
        F_NOR:  ctrl = ULA_NOR;
        F_SLT:  ctrl = ULA_SLT;
        F_SLTU: ctrl = ULA_SLTU;
        default: begin
          ctrl    = ULA_BAD;
          illegal = 1'b1;
        end
      endcase
    end
  end
  assign ULActrl   = CTRL_W'(ctrl);
  assign r_type    = ULAOp == 2'b10 && op_valid;
  assign start_req = r_type && is_md(funct);
  assign stall     = md_busy && r_type && (is_md(funct) || is_hilo(funct));
  assign mf_data   = ULAOp != 2'b10 ? '0 : funct == F_MFHI ? hi_q : funct == F_MFLO ? lo_q : '0;
  assign busy      = md_busy;
  assign hi        = hi_q;
  assign lo        = lo_q;
`ifdef MULDIV_DIVZERO_EXC_EN
  logic exc_q, dz_req;
  assign dz_req = start_req && !md_busy && funct[1] && rt_val == '0;
  assign start  = start_req && !md_busy && !dz_req;
  always_ff @(posedge clk) exc_q <= reset ? 1'b0 : dz_req;
  assign div_zero_exc = exc_q;
`else
  assign start        = start_req && !md_busy;
  assign div_zero_exc = 1'b0;
`endif
  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk    (clk),
    .rst    (reset),
    .start  (start),
    .op_div (funct[1]),
    .op_sgn (~funct[0]),
    .a      (rs_val),
    .b      (rt_val),
    .busy   (md_busy),
    .done   (done),
    .wr     (wr),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );
  // engine writes occur while busy, so they never collide with mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else if (r_type && !md_busy && funct == F_MTHI) hi_q <= rs_val;
    else if (r_type && !md_busy && funct == F_MTLO) lo_q <= rs_val;
  end
endmodule
